// File: rtl/counter_bg_param_if.sv
// rtl/counter_bg_param_if.sv - control and status bundle for counter_bg_param
interface counter_bg_param_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up, mode, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up, mode, load, load_val,
    output count, tc, wrap
  );
endinterface

// File: rtl/counter_bg_param.sv
// rtl/counter_bg_param.sv - up/down counter with run-time binary/Gray encoded output
// Optional COUNTER_SAT_EN: saturate at the terminal value instead of wrapping.
module counter_bg_param #(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic               clk,
  input  logic               reset,
  counter_bg_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] IDX_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] IDX_RST = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idx_next;
  logic             wrap_next;
  logic             tc_int;
  logic [WIDTH-1:0] count_q;
  logic             wrap_q;

  function automatic logic [WIDTH-1:0] enc(input logic [WIDTH-1:0] x, input logic gray);
    return gray ? (x ^ (x >> 1)) : x;
  endfunction

  assign tc_int = bus.up ? (idx == IDX_MAX) : (idx == '0);

  always_comb begin
    idx_next  = idx;
    wrap_next = 1'b0;
    if (bus.load) begin
      idx_next = bus.load_val;
    end else if (bus.en) begin
`ifdef COUNTER_SAT_EN
      // At the terminal value the index parks; wrap can never fire.
      if (!tc_int) begin
        idx_next = bus.up ? (idx + ONE) : (idx - ONE);
      end
`else
      idx_next  = bus.up ? (idx + ONE) : (idx - ONE);
      wrap_next = tc_int;
`endif
    end
  end

  // count is re-encoded from the next index every edge, so a mode change alone
  // re-encodes the current position without moving it.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= IDX_RST;
      count_q <= enc(IDX_RST, bus.mode);
      wrap_q  <= 1'b0;
    end else begin
      idx     <= idx_next;
      count_q <= enc(idx_next, bus.mode);
      wrap_q  <= wrap_next;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = tc_int;

endmodule

// File: tb/tb_counter_bg_param.sv
// tb/tb_counter_bg_param.sv - scoreboard bench for counter_bg_param
module tb_counter_bg_param;

  localparam int W    = 3;
  localparam int MAXV = (1 << W) - 1;
  localparam int RSTV = 0;
`ifdef COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] count;
    logic         wrap;
    logic         tc;
    logic         gray_step;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t q[$];
  exp_t mon_x;
  logic [W-1:0] prev_count = '0;
  int n_cmp = 0;
  int n_fail = 0;
  int m_idx = RSTV;
  bit m_prev_mode = 1'b0;

  counter_bg_param_if #(.WIDTH(W)) bus ();

  counter_bg_param #(.WIDTH(W), .RESET_VAL(RSTV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the counter is a position on a circle of 2**W slots (or a clamped line).
  task automatic step(input bit r, input bit e, input bit u, input bit m,
                      input bit l, input int lv);
    exp_t x;
    int old;
    bit wr;
    @(negedge clk);
    reset = r; bus.en = e; bus.up = u; bus.mode = m; bus.load = l;
    bus.load_val = W'(lv);
    old = m_idx;
    wr = 1'b0;
    if (r) m_idx = RSTV;
    else if (l) m_idx = lv;
    else if (e) begin
      if (u) begin
        if (m_idx == MAXV) begin
          if (!SAT) begin m_idx = 0; wr = 1'b1; end
        end else m_idx = m_idx + 1;
      end else begin
        if (m_idx == 0) begin
          if (!SAT) begin m_idx = MAXV; wr = 1'b1; end
        end else m_idx = m_idx - 1;
      end
    end
    x.count = W'(m ? (m_idx ^ (m_idx / 2)) : m_idx);
    x.wrap = wr;
    x.tc = u ? (m_idx == MAXV) : (m_idx == 0);
    x.gray_step = m && m_prev_mode && (m_idx != old) && !r && !l;
    m_prev_mode = m;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      check("count", int'(bus.count), int'(mon_x.count));
      check("wrap", int'(bus.wrap), int'(mon_x.wrap));
      check("tc", int'(bus.tc), int'(mon_x.tc));
      if (mon_x.gray_step)
        check("gray_onebit", $countones(bus.count ^ prev_count), 1);
      prev_count = bus.count;
    end
  end

  initial begin
    bus.en = 1'b0; bus.up = 1'b1; bus.mode = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    // up-count, binary then Gray, across the wrap
    step(1, 0, 1, 0, 0, 0);
    repeat (9) step(0, 1, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (9) step(0, 1, 1, 1, 0, 0);
    // down through zero, then reverse direction
    step(0, 0, 0, 0, 1, 1);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    // hold with mode toggles
    step(0, 0, 1, 0, 1, 5);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // priorities
    step(0, 1, 1, 0, 1, 6);
    step(1, 1, 1, 0, 1, 3);
    // terminal behaviour from 6
    step(0, 0, 1, 0, 1, 6);
    repeat (3) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, MAXV)));
    end
    @(negedge clk);
    bus.en = 1'b0; bus.load = 1'b0; reset = 1'b0;
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
